// File: rtl/s2p_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserialiser.
// The S2P_PARITY_EN macro appends one parity bit to every frame.
package s2p_pkg;

  typedef enum logic {
    S2P_EMPTY = 1'b0,
    S2P_FULL  = 1'b1
  } s2p_out_st_t;

`ifdef S2P_PARITY_EN
  localparam int S2P_PAR_BITS = 1;
`else
  localparam int S2P_PAR_BITS = 0;
`endif

  // Serial bits per frame: the data bits plus the optional parity bit.
  function automatic int s2p_frame_len(input int data_w);
    return data_w + S2P_PAR_BITS;
  endfunction

  // The counter width must be able to hold FRAME_LEN itself.
  function automatic int s2p_cnt_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/s2p_out_stage.sv
// Output holding register for the deserialiser: one word plus its parity flag.
// It uses a valid/ready handshake and raises a one-cycle overflow pulse when
// a completed word arrives while the held word is still unconsumed.
module s2p_out_stage
  import s2p_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              par_err_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              par_err_o,
  output logic              ovf_o
);

  s2p_out_st_t       st_q, st_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_err_q, par_err_d;
  logic              ovf_q, ovf_d;

  // Next state: load when empty or when draining this cycle, otherwise drop the new word.
  always_comb begin
    st_d      = st_q;
    data_d    = data_q;
    par_err_d = par_err_q;
    ovf_d     = 1'b0;
    case (st_q)
      S2P_EMPTY: begin
        if (load_i) begin
          st_d      = S2P_FULL;
          data_d    = word_i;
          par_err_d = par_err_i;
        end
      end
      S2P_FULL: begin
        if (out_ready_i) begin
          if (load_i) begin
            data_d    = word_i;
            par_err_d = par_err_i;
          end else begin
            st_d = S2P_EMPTY;
          end
        end else if (load_i) begin
          ovf_d = 1'b1;
        end
      end
      default: st_d = S2P_EMPTY;
    endcase
  end

  // State and holding registers; the held word is kept after transfer but no longer valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= S2P_EMPTY;
      data_q    <= '0;
      par_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      data_q    <= data_d;
      par_err_q <= par_err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid_o = (st_q == S2P_FULL);
  assign data_o      = data_q;
  assign par_err_o   = par_err_q;
  assign ovf_o       = ovf_q;

endmodule

// File: rtl/serial2parallel_pro.sv
// Serial-to-parallel deserialiser: shifts in DATA_W qualified bits per frame in the
// selected bit order and hands each completed word to a valid/ready holding stage.
// Defining S2P_PARITY_EN adds a trailing parity bit per frame checked against PAR_ODD.
module serial2parallel_pro
  import s2p_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int MSB_FIRST = 1,
  parameter  int PAR_ODD   = 0,
  localparam int FRAME_LEN = s2p_frame_len(DATA_W),
  localparam int CNT_W     = s2p_cnt_w(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              data_valid_i,
  input  logic              data_in,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  bit_cnt_o,
  output logic              ovf_o,
  output logic              par_err_o
);

  if (DATA_W < 2) begin : g_chk_data_w
    $error("serial2parallel_pro: DATA_W must be at least 2");
  end
  if (PAR_ODD < 0 || PAR_ODD > 1) begin : g_chk_par_odd
    $error("serial2parallel_pro: PAR_ODD must be 0 or 1");
  end

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_shift;
  logic [DATA_W-1:0] word_c;
  logic              par_err_c;
  logic              last_bit;
  logic              data_slot;
  logic              frame_done;

  assign sr_shift   = (MSB_FIRST != 0) ? {sr_q[DATA_W-2:0], data_in}
                                       : {data_in, sr_q[DATA_W-1:1]};
  assign last_bit   = (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign frame_done = data_valid_i & ~clr_i & last_bit;

`ifdef S2P_PARITY_EN
  // The parity bit occupies the last counter slot and never enters the shift register.
  assign data_slot = (cnt_q != CNT_W'(DATA_W));
  assign word_c    = sr_q;
  assign par_err_c = ((^sr_q) ^ data_in) != PAR_ODD[0];
`else
  // The final data bit completes the word in the same cycle it is sampled.
  assign data_slot = 1'b1;
  assign word_c    = sr_shift;
  assign par_err_c = 1'b0;
`endif

  // Frame bookkeeping: clear wins over a same-cycle bit; counter wraps after the last bit.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (data_valid_i) begin
      cnt_d = last_bit ? '0 : cnt_q + 1'b1;
      if (data_slot) begin
        sr_d = sr_shift;
      end
    end
  end

  // Shift register and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  s2p_out_stage #(
    .DATA_W (DATA_W)
  ) u_out_stage (
    .clk         (clk),
    .rst         (rst),
    .load_i      (frame_done),
    .word_i      (word_c),
    .par_err_i   (par_err_c),
    .out_ready_i (out_ready_i),
    .out_valid_o (out_valid_o),
    .data_o      (data_out),
    .par_err_o   (par_err_o),
    .ovf_o       (ovf_o)
  );

  assign bit_cnt_o = cnt_q;

endmodule
